// File: rtl/wb_pkg.sv
// Shared Wishbone types: transfer width encoding, arbiter FSM states, grant index sizing.
package wb_pkg;

    typedef enum logic [1:0] {
        DW_8  = 2'd0,
        DW_16 = 2'd1,
        DW_32 = 2'd2,
        DW_64 = 2'd3
    } eDataWidth;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_MASTERS = 8;

    // Width of a grant index for n masters ($clog2(n), never narrower than 1 bit)
    function automatic int grant_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-priority pick: first set request at or after ptr, wrapping modulo N.
// Purely combinational; gnt is one-hot (or zero when nothing requests), idx its position.
module rr_priority_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any_vld
);

    int k;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_vld = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any_vld && req[k]) begin
                any_vld = 1'b1;
                gnt[k]  = 1'b1;
                idx     = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one owner per bus cycle, 1-cycle arbitration, idle gap between owners.
// Optional hung-slave watchdog enabled by WB_ARB_TIMEOUT_EN.
import wb_pkg::*;

module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             iClk,
    input  logic                             iRst,
    input  logic [N_MASTERS-1:0]             iM_cyc,
    input  logic [N_MASTERS-1:0]             iM_stb,
    input  logic [N_MASTERS-1:0]             iM_we,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  iM_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  iM_data_write,
    input  logic [N_MASTERS*2-1:0]           iM_width,
    output logic [N_MASTERS-1:0]             oM_ack,
    output logic [DATA_WIDTH-1:0]            oM_data_read,
    output logic                             oS_cyc,
    output logic                             oS_stb,
    output logic                             oS_we,
    output logic [ADDR_WIDTH-1:0]            oS_addr,
    output logic [DATA_WIDTH-1:0]            oS_data_write,
    output logic [1:0]                       oS_width,
    input  logic                             iS_ack,
    input  logic [DATA_WIDTH-1:0]            iS_data_read,
    output logic [N_MASTERS-1:0]             oGrant,
    output logic                             oTimeout
);

    localparam int IDX_W = grant_idx_w(N_MASTERS);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    logic [N_MASTERS-1:0] sel_gnt;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_vld;
    logic                 busy;
    logic                 g_cyc;
    logic                 g_stb;
    logic                 to_fire;
    logic [IDX_W-1:0]     next_ptr;

    rr_priority_select #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_sel (
        .req     (iM_cyc),
        .ptr     (ptr_q),
        .gnt     (sel_gnt),
        .idx     (sel_idx),
        .any_vld (sel_vld)
    );

    assign busy     = (state_q == ST_BUSY);
    assign g_cyc    = iM_cyc[gidx_q];
    assign g_stb    = iM_stb[gidx_q];
    assign next_ptr = (gidx_q == IDX_W'(N_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts stalled strobe cycles of the current owner; reset while idle so each owner starts at 0
    always_comb begin
        cnt_d = cnt_q;
        if (!busy || iS_ack) begin
            cnt_d = '0;
        end else if (g_stb) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign to_fire = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d = ST_BUSY;
                    grant_d = sel_gnt;
                    gidx_d  = sel_idx;
                end
            end
            ST_BUSY: begin
                // Releasing always passes through IDLE, which gives the mandatory gap between owners
                if (!g_cyc || to_fire) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        oS_cyc        = 1'b0;
        oS_stb        = 1'b0;
        oS_we         = 1'b0;
        oS_addr       = '0;
        oS_data_write = '0;
        oS_width      = DW_8;
        oM_ack        = '0;
        if (busy) begin
            oS_cyc        = g_cyc;
            oS_stb        = g_stb;
            oS_we         = iM_we[gidx_q];
            oS_addr       = iM_addr[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
            oS_data_write = iM_data_write[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
            oS_width      = iM_width[int'(gidx_q)*2 +: 2];
            if (to_fire || (iS_ack && g_stb)) begin
                oM_ack[gidx_q] = 1'b1;
            end
        end
    end

    assign oM_data_read = to_fire ? {DATA_WIDTH{1'b1}} : iS_data_read;
    assign oGrant       = grant_q;
    assign oTimeout     = to_fire;

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port among N_MASTERS Wishbone masters using round-robin arbitration.
- Sits between CPU-side masters (fetch, load/store, debug) and a single memory or peripheral slave.
- Grants ownership for a whole bus cycle (cyc held high) and muxes addr/data/we/stb/width to the slave.
- Routes ack and data_read back to the granted master only.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width (8/16/32/64)
TIMEOUT_CYCLES, 255, watchdog limit (only used with WB_ARB_TIMEOUT_EN)

Ports:
iClk  in  1  system clock, all logic on rising edge
iRst  in  1  synchronous active-high reset
iM_cyc  in  N_MASTERS  per-master cyc
iM_stb  in  N_MASTERS  per-master stb
iM_we  in  N_MASTERS  per-master write enable
iM_addr  in  N_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
iM_data_write  in  N_MASTERS*DATA_WIDTH  packed write data
iM_width  in  N_MASTERS*2  packed eDataWidth
oM_ack  out  N_MASTERS  per-master ack
oM_data_read  out  DATA_WIDTH  slave read data, broadcast to all masters
oS_cyc, oS_stb, oS_we  out  1 each  to slave
oS_addr  out  ADDR_WIDTH  to slave
oS_data_write  out  DATA_WIDTH  to slave
oS_width  out  2  to slave (eDataWidth)
iS_ack  in  1  from slave
iS_data_read  in  DATA_WIDTH  from slave
oGrant  out  N_MASTERS  one-hot current owner, 0 when idle
oTimeout  out  1  one-cycle pulse on watchdog expiry (tied 0 without the macro)

Behaviour:
- Reset (iRst high at edge):
  - state=IDLE; grant=0; round-robin pointer=0.
  - All oS_* = 0; oM_ack = 0; oGrant = 0; oTimeout = 0.
- Reset mid-cycle: slave cyc/stb drop at the next edge; any pending ack is discarded.
- FSM, state IDLE:
  - If any iM_cyc is high, register the grant to the first requester at or after the pointer, wrapping modulo N_MASTERS; go to BUSY.
  - If no master requests, stay in IDLE.
  - Arbitration latency is 1 cycle: a master raising cyc in cycle t sees oS_cyc high in cycle t+1 at the earliest.
- FSM, state BUSY:
  - oS_* = granted master's signals, combinational from the registered grant.
  - oM_ack[g] = iS_ack when iM_stb[g] is high; all other acks are 0.
  - Grant is held while iM_cyc[g] is high, so multi-beat and RMW cycles are never interleaved.
  - When iM_cyc[g] falls: grant clears, pointer = g+1 mod N, next state IDLE.
  - One idle cycle is guaranteed between owners; oS_cyc is low for at least one cycle.
- IDLE outputs: oS_cyc = oS_stb = 0; remaining oS_* = 0.
- Simultaneous requests: priority starts at the pointer, giving fairness. Example, N=4, pointer=2, requests 4'b1011 -> grant master 3.
- Requester drops cyc before being granted: it is simply not considered at the next arbitration.
- iS_ack while IDLE: ignored; no oM_ack is asserted.
- The arbiter does not hold the granted master's stb; stb is passed through.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY while oS_stb is high and iS_ack is low.
  - When it reaches TIMEOUT_CYCLES: force oM_ack[g]=1 for one cycle with oM_data_read = all-ones, pulse oTimeout, drop the grant, advance the pointer, go to IDLE.
  - The counter clears on any iS_ack and on entry to BUSY.
- WB_ARB_TIMEOUT_EN undefined:
  - No counter.
  - oTimeout tied 0.
  - A hung slave stalls the bus indefinitely.

Decomposition:
- Shared package wb_pkg:
  - eDataWidth enum.
  - Arbiter state enum (IDLE, BUSY).
  - Grant index width constant $clog2(N_MASTERS).
- Sub-module rr_priority_select: combinational; inputs request vector and pointer; outputs one-hot grant and index. Reused by future arbiters.

Test Plan:
- Single master 0, read addr 0x1000, slave acks after 2 cycles with 0xCAFEF00D -> oS_cyc rises 1 cycle after iM_cyc; oM_ack[0] pulses once; data 0xCAFEF00D; oM_ack[1]=0.
- Both masters raise cyc in the same cycle after reset -> master 0 granted first; after it releases, one idle cycle, then master 1 granted; pointer then =0.
- Master 1 holds cyc across 3 beats (write 0x10, 0x14, 0x18) while master 0 requests -> master 0 not granted until master 1 drops cyc; oS_addr never shows master 0's address mid-burst.
- N=4, pointer=2, requests 4'b1011 -> oGrant=4'b1000; next arbitration with 4'b0011 -> oGrant=4'b0001.
- iRst asserted while BUSY mid-transfer -> next cycle oS_cyc=0, oGrant=0; next grant goes to master 0.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> after 8 stalled cycles oM_ack[g]=1, data 0xFFFFFFFF, oTimeout one-cycle pulse, FSM in IDLE.
